// File: rtl/jt12_eg_phase.sv
// -----------------------------------------------------------------------------
// jt12_eg_phase
// Envelope-generator phase tracker for a time-multiplexed FM operator pipeline.
// Each of SLOTS slots owns a {phase, prev_kon} record that circulates through a
// shift register, one stage per clk_en.  The record reaching the last stage
// belongs to the slot whose inputs are currently presented.  Its next phase is
// computed, written back into stage 0 and registered onto the outputs.
//
// Optional feature: define JT12_EG_SSG_EN to compile in the SSG-EG loop
// restart (adds ssg_en input and ssg_restart output).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   clk_en       pipeline advance strobe; everything holds while low
//   keyon_II     key-on level of the head slot
//   eg_in[9:0]   current attenuation of the head slot (0 loudest, 0x3FF silent)
//   sl[3:0]      sustain level of the head slot
//   ssg_en       (JT12_EG_SSG_EN only) SSG-EG enable of the head slot
//   state_out    registered phase of the slot just processed
//   kon_pulse    one-slot key-on edge marker
//   koff_pulse   one-slot key-off edge marker
//   ssg_restart  (JT12_EG_SSG_EN only) one-slot SSG loop restart marker
//
// Per-slot phase
//   state   | meaning
//   ATTACK  | attenuation ramping towards 0 after key-on
//   DECAY   | falling from peak towards the sustain level
//   SUSTAIN | holding at/below sustain level until key-off
//   RELEASE | key released (also the reset state)
// -----------------------------------------------------------------------------
module jt12_eg_phase #(
    parameter int SLOTS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       keyon_II,
    input  logic [9:0] eg_in,
    input  logic [3:0] sl,
`ifdef JT12_EG_SSG_EN
    input  logic       ssg_en,
    output logic       ssg_restart,
`endif
    output logic [1:0] state_out,
    output logic       kon_pulse,
    output logic       koff_pulse
);

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } phase_t;

    // Each stage: {phase[1:0], prev_kon}
    logic [SLOTS-1:0][2:0] r_stage;
    logic [1:0]            r_state_out;
    logic                  r_kon_pulse;
    logic                  r_koff_pulse;

    phase_t     w_cur;
    logic       w_prev_kon;
    phase_t     w_next;
    logic       w_kon;
    logic       w_koff;
    logic [9:0] w_sl_ext;
    logic [2:0] w_new_stage;

    assign w_cur       = phase_t'(r_stage[SLOTS-1][2:1]);
    assign w_prev_kon  = r_stage[SLOTS-1][0];
    assign w_new_stage = {w_next, keyon_II};

`ifdef JT12_EG_SSG_EN
    logic r_ssg_restart;
    logic w_ssg;
    assign ssg_restart = r_ssg_restart;
`endif

    always_comb begin
        w_next   = w_cur;
        w_kon    = 1'b0;
        w_koff   = 1'b0;
`ifdef JT12_EG_SSG_EN
        w_ssg    = 1'b0;
`endif
        // sl = 15 is the special maximum level rather than 0x1E0
        w_sl_ext = (sl == 4'hF) ? 10'h3E0 : {1'b0, sl, 5'b0};

        if (keyon_II && !w_prev_kon) begin
            w_next = ATTACK;
            w_kon  = 1'b1;
        end else if (!keyon_II && w_prev_kon) begin
            w_next = RELEASE;
            w_koff = 1'b1;
        end
`ifdef JT12_EG_SSG_EN
        // No edge here, so keyon_II = 1 means the key is held
        else if (ssg_en && keyon_II && (w_cur == DECAY || w_cur == SUSTAIN) &&
                 (eg_in >= 10'h200)) begin
            w_next = ATTACK;
            w_ssg  = 1'b1;
        end
`endif
        else begin
            case (w_cur)
                ATTACK:  if (eg_in == 10'd0)     w_next = DECAY;
                DECAY:   if (eg_in >= w_sl_ext)  w_next = SUSTAIN;
                default: w_next = w_cur;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage      <= {SLOTS{3'b110}};
            r_state_out  <= RELEASE;
            r_kon_pulse  <= 1'b0;
            r_koff_pulse <= 1'b0;
        end else if (clk_en) begin
            r_stage      <= {r_stage[SLOTS-2:0], w_new_stage};
            r_state_out  <= w_next;
            r_kon_pulse  <= w_kon;
            r_koff_pulse <= w_koff;
        end
    end

`ifdef JT12_EG_SSG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssg_restart <= 1'b0;
        end else if (clk_en) begin
            r_ssg_restart <= w_ssg;
        end
    end
`endif

    assign state_out  = r_state_out;
    assign kon_pulse  = r_kon_pulse;
    assign koff_pulse = r_koff_pulse;

endmodule

// File: tb/tb_jt12_eg_phase.sv
module tb_jt12_eg_phase;

    localparam int SLOTS = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       keyon_II = 1'b0;
    logic [9:0] eg_in = 10'h3FF;
    logic [3:0] sl = 4'd0;
    logic [1:0] state_out;
    logic       kon_pulse;
    logic       koff_pulse;
`ifdef JT12_EG_SSG_EN
    logic       ssg_en = 1'b0;
    logic       ssg_restart;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    jt12_eg_phase #(.SLOTS(SLOTS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .keyon_II   (keyon_II),
        .eg_in      (eg_in),
        .sl         (sl),
`ifdef JT12_EG_SSG_EN
        .ssg_en     (ssg_en),
        .ssg_restart(ssg_restart),
`endif
        .state_out  (state_out),
        .kon_pulse  (kon_pulse),
        .koff_pulse (koff_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       kon;
        logic [9:0] eg;
        logic [3:0] sl;
        logic [1:0] st;
        logic       kp;
        logic       kf;
        int         hold;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic kon, input logic [9:0] eg, input logic [3:0] s);
        @(negedge clk);
        keyon_II = kon;
        eg_in    = eg;
        sl       = s;
        clk_en   = 1'b1;
        @(posedge clk);
        #1;
        clk_en   = 1'b0;
    endtask

    // One full rotation; tslot gets the vector, every other slot gets key off.
    task automatic run_round(input int tslot, input vec_t v, input string name);
        int bad = 0;
        int bad_slot = -1;
        for (int s = 0; s < SLOTS; s++) begin
            if (s == tslot) begin
                step(v.kon, v.eg, v.sl);
                check({name, " state"}, 32'(state_out), 32'(v.st));
                check({name, " kon"},   32'(kon_pulse), 32'(v.kp));
                check({name, " koff"},  32'(koff_pulse), 32'(v.kf));
                if (v.hold > 0) begin
                    // Inputs that would change things if clk_en were ignored
                    keyon_II = ~v.kon;
                    eg_in    = 10'h000;
                    sl       = 4'hF;
                    repeat (v.hold) @(posedge clk);
                    #1;
                    check({name, " hold state"}, 32'(state_out), 32'(v.st));
                    check({name, " hold kon"},   32'(kon_pulse), 32'(v.kp));
                    check({name, " hold koff"},  32'(koff_pulse), 32'(v.kf));
                end
            end else begin
                step(1'b0, 10'h3FF, 4'd0);
                if (state_out !== 2'd3 || kon_pulse !== 1'b0 || koff_pulse !== 1'b0) begin
                    if (bad == 0) bad_slot = s;
                    bad++;
                end
            end
        end
        if (bad != 0)
            $display("FAIL %s other slots: first bad slot %0d", name, bad_slot);
        check({name, " other slots bad count"}, 32'(bad), 32'd0);
    endtask

`ifdef JT12_EG_SSG_EN
    task automatic ssg_round(input int tslot, input logic kon, input logic [9:0] eg,
                             input logic [3:0] s, input logic en, input logic [1:0] est,
                             input logic erst, input string name);
        for (int k = 0; k < SLOTS; k++) begin
            if (k == tslot) begin
                ssg_en = en;
                step(kon, eg, s);
                ssg_en = 1'b0;
                check({name, " state"},   32'(state_out), 32'(est));
                check({name, " restart"}, 32'(ssg_restart), 32'(erst));
            end else begin
                step(1'b0, 10'h3FF, 4'd0);
            end
        end
    endtask
`endif

    initial begin
        //         kon   eg      sl     st    kp    kf    hold
        vecs[0]  = '{1'b1, 10'h3FF, 4'd0,  2'd0, 1'b1, 1'b0, 3};
        vecs[1]  = '{1'b1, 10'h000, 4'd0,  2'd1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 10'h07F, 4'd4,  2'd1, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b1, 10'h080, 4'd4,  2'd2, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b1, 10'h3FF, 4'd4,  2'd2, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 10'h100, 4'd4,  2'd3, 1'b0, 1'b1, 0};
        vecs[6]  = '{1'b0, 10'h100, 4'd4,  2'd3, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b1, 10'h000, 4'd0,  2'd0, 1'b1, 1'b0, 0};
        vecs[8]  = '{1'b1, 10'h000, 4'd0,  2'd1, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 10'h3DF, 4'd15, 2'd1, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b1, 10'h3E0, 4'd15, 2'd2, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b1, 10'h000, 4'd15, 2'd2, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b0, 10'h000, 4'd0,  2'd3, 1'b0, 1'b1, 0};
        vecs[13] = '{1'b0, 10'h000, 4'd0,  2'd3, 1'b0, 1'b0, 0};
        vecs[14] = '{1'b1, 10'h100, 4'd0,  2'd0, 1'b1, 1'b0, 0};
        vecs[15] = '{1'b1, 10'h100, 4'd0,  2'd0, 1'b0, 1'b0, 0};
        vecs[16] = '{1'b0, 10'h100, 4'd0,  2'd3, 1'b0, 1'b1, 0};

        // Reset values while rst_n is held low with the clock running
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(state_out), 32'd3);
        check("reset kon",   32'(kon_pulse), 32'd0);
        check("reset koff",  32'(koff_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle rotation: all slots released, no pulses
        run_round(0, '{1'b0, 10'h3FF, 4'd0, 2'd3, 1'b0, 1'b0, 0}, "idle");

        for (int i = 0; i < 17; i++)
            run_round(5, vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of an attack on slot 5
        for (int s = 0; s < 5; s++) step(1'b0, 10'h3FF, 4'd0);
        step(1'b1, 10'h100, 4'd0);
        check("pre-reset state", 32'(state_out), 32'd0);
        check("pre-reset kon",   32'(kon_pulse), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset state", 32'(state_out), 32'd3);
        check("async reset kon",   32'(kon_pulse), 32'd0);
        @(posedge clk);
        #1;
        check("held reset state", 32'(state_out), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        // Slot 5 key history must be gone: key off is not an edge now
        run_round(5, '{1'b0, 10'h100, 4'd0, 2'd3, 1'b0, 1'b0, 0}, "post-reset off");
        run_round(5, '{1'b1, 10'h3FF, 4'd0, 2'd0, 1'b1, 1'b0, 0}, "post-reset kon");
        run_round(5, '{1'b0, 10'h3FF, 4'd0, 2'd3, 1'b0, 1'b1, 0}, "post-reset koff");

`ifdef JT12_EG_SSG_EN
        ssg_round(5, 1'b1, 10'h3FF, 4'd0, 1'b1, 2'd0, 1'b0, "ssg kon");
        ssg_round(5, 1'b1, 10'h000, 4'd0, 1'b0, 2'd1, 1'b0, "ssg to decay");
        ssg_round(5, 1'b1, 10'h000, 4'd0, 1'b0, 2'd2, 1'b0, "ssg to sustain");
        ssg_round(5, 1'b1, 10'h1FF, 4'd0, 1'b1, 2'd2, 1'b0, "ssg below 0x200");
        ssg_round(5, 1'b1, 10'h200, 4'd0, 1'b1, 2'd0, 1'b1, "ssg restart");
        ssg_round(5, 1'b1, 10'h100, 4'd0, 1'b1, 2'd0, 1'b0, "ssg restart clears");
        ssg_round(5, 1'b0, 10'h300, 4'd0, 1'b1, 2'd3, 1'b0, "ssg koff priority");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jt12_eg_phase.md
JT12_EG_PHASE -- requirements
Module: jt12_eg_phase

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: SLOTS, default 24, the number of slots in the time-multiplexed pipeline.
REQ-003 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: clk_en  input  1  pipeline advance strobe; state is held when low.
REQ-006 Port: keyon_II  input  1  key-on level for the slot at the pipeline head, from the key-on stage.
REQ-007 Port: eg_in  input  10  current attenuation of the head slot; 0 = loudest, 0x3FF = silent.
REQ-008 Port: sl  input  4  sustain level of the head slot.
REQ-009 Port: state_out  output  2  registered envelope phase of the slot just processed: 0 = ATTACK, 1 = DECAY, 2 = SUSTAIN, 3 = RELEASE.
REQ-010 Port: kon_pulse  output  1  one-slot pulse marking a key-on edge.
REQ-011 Port: koff_pulse  output  1  one-slot pulse marking a key-off edge.

Function
REQ-012 Per-slot storage SHALL be a SLOTS-stage shift register holding {phase[1:0], prev_kon}, advanced once per clk_en.
REQ-013 The head slot SHALL be processed in the same clk_en cycle that its keyon_II, eg_in and sl are presented; outputs SHALL be registered with a latency of 1 clk_en.
REQ-014 The sustain threshold SHALL be sl_ext = {1'b0, sl, 5'b0}, with sl = 15 mapped to 0x3E0.
REQ-015 Next-state priority, highest first: key-on edge, key-off edge, phase progression, hold.
REQ-016 Key-on edge (keyon_II = 1, prev_kon = 0): next phase = ATTACK and kon_pulse = 1, regardless of the current phase.
REQ-017 Key-off edge (keyon_II = 0, prev_kon = 1): next phase = RELEASE and koff_pulse = 1, regardless of the current phase.
REQ-018 Phase progression: ATTACK with eg_in == 0 goes to DECAY.
REQ-019 Phase progression: DECAY with eg_in >= sl_ext goes to SUSTAIN.
REQ-020 Phase progression: SUSTAIN and RELEASE hold until the next edge.
REQ-021 A key-on edge in ATTACK with eg_in == 0 SHALL stay in ATTACK (restart), not go to DECAY.
REQ-022 The stored prev_kon SHALL be updated to keyon_II on every processed slot.
REQ-023 With clk_en low: no shift, outputs hold, and no pulses are generated.
REQ-024 Pulses SHALL last exactly one clk_en slot and SHALL be cleared on the next clk_en.
REQ-025 The phase of a slot SHALL depend only on that slot's history, with no crosstalk between slots.

Reset
REQ-026 While rst_n = 0, every stage SHALL be set to phase RELEASE with prev_kon = 0, asynchronously.
REQ-027 While rst_n = 0, state_out SHALL be 3 and kon_pulse = koff_pulse = 0.
REQ-028 Reset asserted mid-operation SHALL discard all slot state immediately.
REQ-029 After reset release, a slot that sees keyon_II = 1 on its first visit SHALL register a key-on edge.

Configuration
REQ-030 The SSG-EG loop feature SHALL be compiled in only when the macro JT12_EG_SSG_EN is defined.
REQ-031 With JT12_EG_SSG_EN: input port ssg_en (1 bit) and output port ssg_restart (1 bit) SHALL exist.
REQ-032 With JT12_EG_SSG_EN: a slot in DECAY or SUSTAIN with ssg_en = 1, keyon_II = 1 held (no edge) and eg_in >= 0x200 SHALL go to ATTACK with ssg_restart = 1 for one slot.
REQ-033 With JT12_EG_SSG_EN: key-on and key-off edges SHALL still take priority over the SSG restart.
REQ-034 Without JT12_EG_SSG_EN: ssg_en and ssg_restart SHALL be absent and behaviour SHALL be exactly REQ-012 to REQ-025.

Verification
REQ-035 Reset, then 24 clk_en with keyon_II = 0 -> state_out = 3 on every slot, no pulses.
REQ-036 Slot 5: keyon_II = 1, eg_in = 0x3FF -> next output state_out = 0, kon_pulse = 1.
REQ-037 Slot 5, next visits: eg_in = 0 -> state_out = 1; then sl = 4 with eg_in = 0x080 -> state_out = 2; slot 6 stays 3.
REQ-038 Slot 5 in SUSTAIN, keyon_II = 0 -> state_out = 3, koff_pulse = 1; next visit with keyon_II = 0 -> koff_pulse = 0.
REQ-039 sl = 15: DECAY with eg_in = 0x3DF stays 1; with eg_in = 0x3E0 -> 2.
REQ-040 With JT12_EG_SSG_EN, ssg_en = 1, SUSTAIN, keyon held, eg_in = 0x200 -> state_out = 0, ssg_restart = 1.
REQ-041 rst_n pulsed low mid-ATTACK -> all slots read 3 immediately.
